// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions for the fetch stage and control unit: instruction field
// positions, the fetch FSM state type and the opcode encodings decode matches on.
package legv8_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int OPCODE_MSB  = 31;
  localparam int OPCODE_LSB  = 21;
  localparam int OPCODE_W    = OPCODE_MSB - OPCODE_LSB + 1;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } fetch_state_t;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [31:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/instruction_fetch_pc_reg.sv
// Program counter: advances by one instruction on load, or jumps to a word-aligned
// redirect target, which takes priority.
module pc_reg
  import legv8_pkg::*;
#(
  parameter int                   PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] target,
  output logic [PC_WIDTH-1:0] pc
);

  // Low two target bits are dropped so the PC is always instruction aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= target & ~PC_WIDTH'(3);
    end else if (load) begin
      pc <= pc + PC_WIDTH'(INSTR_BYTES);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// LEGv8 fetch stage with IF/ID register: requests instructions over req/ack, holds them
// for decode across stalls, and redirects/flushes on a taken branch.
module instruction_fetch
  import legv8_pkg::*;
#(
  parameter int                   PC_WIDTH    = 64,
  parameter int                   INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
  input  logic                   CLOCK,
  input  logic                   RESET_N,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  input  logic                   stall_in,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [OPCODE_W-1:0]    controlInstruction_out,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic                   instr_valid
);

  fetch_state_t        state;
  logic [PC_WIDTH-1:0] pc;
  logic                accept;

  // A stalled, occupied IF/ID has nowhere to put a new word, so the request is withheld
  // rather than letting memory complete a transfer that would have to be thrown away.
  always_comb begin
    imem_req = (state == FETCH) && !(stall_in && instr_valid);
    accept   = imem_req && imem_ack && !branch_taken;
  end

  assign imem_addr              = pc;
  assign controlInstruction_out = instr_out[INSTR_WIDTH-1 -: OPCODE_W];

  pc_reg #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (CLOCK),
    .rst_n    (RESET_N),
    .load     (accept),
    .redirect (branch_taken),
    .target   (branch_target),
    .pc       (pc)
  );

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= BOOT;
      instr_out   <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
    end else if (branch_taken) begin
      state       <= FETCH;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= FETCH;
        FETCH: begin
          if (accept) begin
            instr_out   <= imem_data;
            pc_out      <= pc;
            instr_valid <= 1'b1;
          end else if (stall_in) begin
            state <= STALL;
          end else begin
            instr_valid <= 1'b0;
          end
        end
        // Leaving STALL means decode took the held word this cycle, so it becomes a bubble.
        STALL: begin
          if (!stall_in) begin
            state       <= FETCH;
            instr_valid <= 1'b0;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: boot, delayed ack, stall, branch flush, PC wrap
// and asynchronous reset mid-request, with hand-computed expectations.
module tb_instruction_fetch;

  logic        CLOCK = 1'b0;
  logic        RESET_N;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        stall_in;
  logic        branch_taken;
  logic [63:0] branch_target;

  logic        imem_req, imem_req2;
  logic [63:0] imem_addr, imem_addr2;
  logic [31:0] instr_out, instr_out2;
  logic [10:0] ctrl_op, ctrl_op2;
  logic [63:0] pc_out, pc_out2;
  logic        instr_valid, instr_valid2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLOCK = ~CLOCK;

  instruction_fetch #(.PC_WIDTH(64), .INSTR_WIDTH(32), .RESET_PC(64'h0)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .stall_in(stall_in), .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_out(instr_out), .controlInstruction_out(ctrl_op), .pc_out(pc_out),
    .instr_valid(instr_valid)
  );

  instruction_fetch #(.PC_WIDTH(64), .INSTR_WIDTH(32), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
    .CLOCK(CLOCK), .RESET_N(RESET_N),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack), .imem_data(imem_data),
    .stall_in(stall_in), .branch_taken(branch_taken), .branch_target(branch_target),
    .instr_out(instr_out2), .controlInstruction_out(ctrl_op2), .pc_out(pc_out2),
    .instr_valid(instr_valid2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  // Ends one cycle after release, with the FSM just out of BOOT and in FETCH.
  task automatic do_reset();
    RESET_N = 1'b0; imem_ack = 1'b0; stall_in = 1'b0; branch_taken = 1'b0;
    step();
    step();
    RESET_N = 1'b1;
    chk("boot_req", imem_req, 0);
    step();
  endtask

  initial begin
    RESET_N = 1'b0; imem_ack = 1'b0; imem_data = '0; stall_in = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    step();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr_out, 0);
    chk("rst_op", ctrl_op, 0);
    chk("rst_pc_out", pc_out, 0);

    // 1: back-to-back acks
    do_reset();
    chk("t1_req", imem_req, 1);
    chk("t1_addr0", imem_addr, 64'h0);
    chk("t5_addr_reset", imem_addr2, 64'hFFFF_FFFF_FFFF_FFFC);
    imem_ack = 1'b1; imem_data = 32'hF840_0000;
    step();
    chk("t1_valid0", instr_valid, 1);
    chk("t1_pc0", pc_out, 64'h0);
    chk("t1_op0", ctrl_op, 11'b11111000010);
    chk("t1_addr4", imem_addr, 64'h4);
    chk("t5_addr_wrap", imem_addr2, 64'h0);
    chk("t5_pc_out", pc_out2, 64'hFFFF_FFFF_FFFF_FFFC);
    imem_data = 32'h8B00_0000;
    step();
    chk("t1_valid1", instr_valid, 1);
    chk("t1_pc1", pc_out, 64'h4);
    chk("t1_op1", ctrl_op, 11'b10001011000);
    chk("t1_addr8", imem_addr, 64'h8);
    imem_ack = 1'b0;

    // 2: ack delayed 3 cycles
    do_reset();
    chk("t2_addr_c0", imem_addr, 64'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_addr_hold", imem_addr, 64'h0);
      chk("t2_req_hold", imem_req, 1);
      chk("t2_bubble", instr_valid, 0);
    end
    imem_ack = 1'b1; imem_data = 32'hF840_0000;
    step();
    chk("t2_valid", instr_valid, 1);
    chk("t2_pc_out", pc_out, 64'h0);
    imem_ack = 1'b0;

    // 3: stall two cycles after first instruction
    stall_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t3_req_low", imem_req, 0);
      chk("t3_valid_hold", instr_valid, 1);
      chk("t3_instr_hold", instr_out, 32'hF840_0000);
      chk("t3_pc_hold", pc_out, 64'h0);
    end
    stall_in = 1'b0;
    step();
    chk("t3_req_resume", imem_req, 1);
    chk("t3_addr_resume", imem_addr, 64'h4);

    // 4: branch beats same-cycle ack
    imem_ack = 1'b1; imem_data = 32'h1234_5678;
    branch_taken = 1'b1; branch_target = 64'h103;
    step();
    branch_taken = 1'b0; imem_ack = 1'b0;
    chk("t4_valid", instr_valid, 0);
    chk("t4_addr", imem_addr, 64'h100);
    chk("t4_instr_kept", instr_out, 32'hF840_0000);

    // 6: asynchronous reset mid-request
    imem_ack = 1'b1; imem_data = 32'h8B00_0000;
    step();
    imem_ack = 1'b0;
    chk("t6_valid_pre", instr_valid, 1);
    chk("t6_pc_pre", pc_out, 64'h100);
    chk("t6_req_pre", imem_req, 1);
    RESET_N = 1'b0;
    #1;
    chk("t6_req_drop", imem_req, 0);
    chk("t6_valid_drop", instr_valid, 0);
    chk("t6_addr_reset", imem_addr, 64'h0);
    step();
    RESET_N = 1'b1;
    chk("t6_boot_req", imem_req, 0);
    step();
    chk("t6_refetch_req", imem_req, 1);
    chk("t6_refetch_addr", imem_addr, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
